// File: rtl/mb_fetch.sv
// Macroblock fetcher: reads one 16x16 NV12 macroblock (32 luma + 16 UV words) and streams it downstream.
// Optional macro MB_FETCH_STALL_CNT_EN adds a downstream stall-cycle counter output.
`timescale 1ns/1ps
module mb_fetch #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32,
    parameter int MB_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [MB_W-1:0]   mb_x_i,
    input  logic [MB_W-1:0]   mb_y_i,
    input  logic [MB_W-1:0]   pic_width_mb_i,
    input  logic [ADDR_W-1:0] y_base_i,
    input  logic [ADDR_W-1:0] uv_base_i,
    output logic              busy_o,
    output logic              fetch_done_o,
    output logic              load_start_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [63:0]       mem_rdata_i,
    output logic              pvalid_o,
    input  logic              pready_i,
    output logic [63:0]       pdata_o
`ifdef MB_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [63:0] byte_rev(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[8*(7-i) +: 8];
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [MB_W-1:0]   mb_x_q, mb_x_d, mb_y_q, mb_y_d;
    logic [ADDR_W-1:0] stride_q, stride_d, y_base_q, y_base_d, uv_base_q, uv_base_d;
    logic [ADDR_W-1:0] row_q, row_d, uv_row0_q, uv_row0_d, mem_addr_q, mem_addr_d;
    logic [5:0]        req_cnt_q, req_cnt_d, xfer_cnt_q, xfer_cnt_d;
    logic              mem_req_q, mem_req_d, busy_q, busy_d;
    logic              load_start_q, load_start_d, fetch_done_q, fetch_done_d;
    logic [63:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              pvalid_q, pvalid_d;
    logic              xfer_s, gnt_s;
    logic [6:0]        outstanding_s;
    logic [ADDR_W-1:0] ymul_s, xoff_s, y_row0_s, uv_row0_s;
`ifdef MB_FETCH_STALL_CNT_EN
    logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

    // Row-0 base addresses: the only multiply, evaluated once per fetch during SETUP.
    assign ymul_s    = ADDR_W'(mb_y_q) * stride_q;
    assign xoff_s    = ADDR_W'({mb_x_q, 4'b0000});
    assign y_row0_s  = y_base_q + {ymul_s[ADDR_W-5:0], 4'b0000} + xoff_s;
    assign uv_row0_s = uv_base_q + {ymul_s[ADDR_W-4:0], 3'b000} + xoff_s;

    // Next-state logic for the sequencer, request generator and return FIFO.
    always_comb begin
        state_d    = state_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        stride_d   = stride_q;
        y_base_d   = y_base_q;
        uv_base_d  = uv_base_q;
        row_d      = row_q;
        uv_row0_d  = uv_row0_q;
        req_cnt_d  = req_cnt_q;
        xfer_s     = pvalid_q && pready_i;
        gnt_s      = mem_req_q && mem_gnt_i;
        if (xfer_s) begin
            xfer_cnt_d = xfer_cnt_q + 6'd1;
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
`ifdef MB_FETCH_STALL_CNT_EN
        stall_cnt_d = stall_cnt_q;
        if (pvalid_q && !pready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mb_x_d    = mb_x_i;
                    mb_y_d    = mb_y_i;
                    stride_d  = ADDR_W'({pic_width_mb_i, 4'b0000});
                    y_base_d  = y_base_i;
                    uv_base_d = uv_base_i;
                    state_d   = S_SETUP;
`ifdef MB_FETCH_STALL_CNT_EN
                    stall_cnt_d = 16'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                row_d      = y_row0_s;
                uv_row0_d  = uv_row0_s;
                req_cnt_d  = 6'd0;
                xfer_cnt_d = 6'd0;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                // Odd request closes a row; request 31 hands over to the UV plane.
                if (gnt_s) begin
                    req_cnt_d = req_cnt_q + 6'd1;
                    if (req_cnt_q == 6'd31) begin
                        row_d = uv_row0_q;
                    end else if (req_cnt_q[0]) begin
                        row_d = row_q + stride_q;
                    end else begin
                        row_d = row_q;
                    end
                end else begin
                    req_cnt_d = req_cnt_q;
                end
                if (req_cnt_d == 6'd48) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (xfer_cnt_d == 6'd48) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                xfer_cnt_d = 6'd0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        outstanding_s = {1'b0, req_cnt_d} - {1'b0, xfer_cnt_d};
        if (mem_req_q && !mem_gnt_i) begin
            mem_req_d = 1'b1;
        end else if ((state_d == S_ISSUE) && (req_cnt_d < 6'd48) && (outstanding_s < 7'(FIFO_DEPTH))) begin
            mem_req_d = 1'b1;
        end else begin
            mem_req_d = 1'b0;
        end
        mem_addr_d   = row_d + ADDR_W'({req_cnt_d[0], 3'b000});
        busy_d       = (state_d != S_IDLE);
        load_start_d = (state_d == S_SETUP);
        fetch_done_d = (state_d == S_DONE);

        wr_ptr_d = mem_rvalid_i ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = xfer_s ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
        case ({mem_rvalid_i, xfer_s})
            2'b10:   count_d = count_q + (PW+1)'(1'b1);
            2'b01:   count_d = count_q - (PW+1)'(1'b1);
            default: count_d = count_q;
        endcase
        pvalid_d = (count_d != '0);
    end

    // State, datapath and FIFO storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mb_x_q       <= '0;
            mb_y_q       <= '0;
            stride_q     <= '0;
            y_base_q     <= '0;
            uv_base_q    <= '0;
            row_q        <= '0;
            uv_row0_q    <= '0;
            mem_addr_q   <= '0;
            req_cnt_q    <= 6'd0;
            xfer_cnt_q   <= 6'd0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            load_start_q <= 1'b0;
            fetch_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pvalid_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 64'd0;
            end
`ifdef MB_FETCH_STALL_CNT_EN
            stall_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            mb_x_q       <= mb_x_d;
            mb_y_q       <= mb_y_d;
            stride_q     <= stride_d;
            y_base_q     <= y_base_d;
            uv_base_q    <= uv_base_d;
            row_q        <= row_d;
            uv_row0_q    <= uv_row0_d;
            mem_addr_q   <= mem_addr_d;
            req_cnt_q    <= req_cnt_d;
            xfer_cnt_q   <= xfer_cnt_d;
            mem_req_q    <= mem_req_d;
            busy_q       <= busy_d;
            load_start_q <= load_start_d;
            fetch_done_q <= fetch_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pvalid_q     <= pvalid_d;
            if (mem_rvalid_i) begin
                fifo_mem_q[wr_ptr_q] <= byte_rev(mem_rdata_i);
            end
`ifdef MB_FETCH_STALL_CNT_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign fetch_done_o = fetch_done_q;
    assign load_start_o = load_start_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign pvalid_o     = pvalid_q;
    assign pdata_o      = fifo_mem_q[rd_ptr_q];
`ifdef MB_FETCH_STALL_CNT_EN
    assign stall_cnt_o  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mb_fetch.sv
// Scoreboard bench for mb_fetch: expected addresses/words queued at start, popped by a monitor on grant/transfer.
`timescale 1ns/1ps
module tb_mb_fetch;
    localparam int DEPTH = 8;
    localparam logic [31:0] SPECIAL = 32'h0001_0000;

    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
    logic [7:0] mb_x_i = 8'd0, mb_y_i = 8'd0, pic_width_mb_i = 8'd0;
    logic [31:0] y_base_i = 32'd0, uv_base_i = 32'd0;
    logic busy_o, fetch_done_o, load_start_o, mem_req_o, pvalid_o;
    logic [31:0] mem_addr_o;
    logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, pready_i = 1'b1;
    logic [63:0] mem_rdata_i = 64'd0, pdata_o;
`ifdef MB_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    mb_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .MB_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mb_x_i(mb_x_i), .mb_y_i(mb_y_i),
        .pic_width_mb_i(pic_width_mb_i), .y_base_i(y_base_i), .uv_base_i(uv_base_i),
        .busy_o(busy_o), .fetch_done_o(fetch_done_o), .load_start_o(load_start_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .pvalid_o(pvalid_o),
        .pready_i(pready_i), .pdata_o(pdata_o)
`ifdef MB_FETCH_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] d; int due; } pend_t;
    pend_t pend_q[$];
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_data_q[$];
    logic [31:0] addr_log[48];

    int checks = 0, errors = 0;
    int gnt_mode = 0, lat_max = 1, rdy_mode = 0, stall_at = 0, stall_left = 0;
    int gcnt, tcnt, ls_cnt, fd_cnt, viol, max_out, done_it, last_xfer_it, req_drop, mit = 0, dcyc = 0;
    bit mon_en = 1'b0, done_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] data_fn(input logic [31:0] a);
        if (a == SPECIAL) return 64'h0706050403020100;
        return {~a, a ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [63:0] brev(input logic [63:0] x);
        logic [63:0] r;
        r = {<<8{x}};
        return r;
    endfunction

    // Memory and downstream-ready driver, active on the falling edge.
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_q.delete();
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; pready_i = 1'b1;
                continue;
            end
            dcyc++;
            mem_gnt_i = mem_req_o && (gnt_mode == 0 || $urandom_range(1, 0) == 1);
            if (mem_gnt_i) begin
                p.d = data_fn(mem_addr_o);
                p.due = dcyc + ((lat_max <= 1) ? 1 : int'($urandom_range(lat_max, 1)));
                pend_q.push_back(p);
            end
            if (pend_q.size() > 0 && pend_q[0].due <= dcyc) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = pend_q[0].d; void'(pend_q.pop_front());
            end else begin
                mem_rvalid_i = 1'b0; mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            case (rdy_mode)
                1: begin
                    if (stall_left > 0 && tcnt >= stall_at) begin pready_i = 1'b0; stall_left--; end
                    else pready_i = 1'b1;
                end
                2: pready_i = ($urandom_range(3, 0) != 0);
                3: begin
                    if (stall_left > 0 && pvalid_o) begin pready_i = 1'b0; stall_left--; end
                    else pready_i = 1'b1;
                end
                default: pready_i = 1'b1;
            endcase
        end
    end

    // Monitor: samples between edges and checks each grant and transfer against the scoreboard.
    initial begin
        bit prev_req_hold, prev_p_hold, prev_rv_empty;
        logic [31:0] prev_addr;
        logic [63:0] prev_pdata;
        prev_req_hold = 1'b0; prev_p_hold = 1'b0; prev_rv_empty = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!mon_en || !rst_n) begin
                prev_req_hold = 1'b0; prev_p_hold = 1'b0; prev_rv_empty = 1'b0;
                continue;
            end
            mit++;
            if (mem_req_o && (gcnt - tcnt) >= DEPTH) viol++;
            if (mem_req_o == 1'b0 && pready_i == 1'b0) req_drop++;
            if (prev_req_hold) begin
                chk("req_held", mem_req_o, 1'b1);
                chk("addr_stable", mem_addr_o, prev_addr);
            end
            if (prev_p_hold) begin
                chk("pvalid_held", pvalid_o, 1'b1);
                chk("pdata_stable", pdata_o, prev_pdata);
            end
            if (prev_rv_empty) chk("rvalid_to_pvalid", pvalid_o, 1'b1);
            if (load_start_o) begin ls_cnt++; chk("busy_at_load_start", busy_o, 1'b1); end
            if (fetch_done_o) begin fd_cnt++; done_it = mit; done_seen = 1'b1; end
            if (mem_req_o && mem_gnt_i) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_addr: got %h expected none (extra request)", mem_addr_o);
                end else chk("mem_addr", mem_addr_o, exp_addr_q.pop_front());
                if (gcnt < 48) addr_log[gcnt] = mem_addr_o;
                gcnt++;
            end
            if (pvalid_o && pready_i) begin
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pdata: got %h expected none (extra word)", pdata_o);
                end else chk("pdata", pdata_o, exp_data_q.pop_front());
                tcnt++; last_xfer_it = mit;
            end
            if (gcnt - tcnt > max_out) max_out = gcnt - tcnt;
            prev_req_hold = mem_req_o && !mem_gnt_i; prev_addr = mem_addr_o;
            prev_p_hold = pvalid_o && !pready_i;    prev_pdata = pdata_o;
            prev_rv_empty = mem_rvalid_i && !pvalid_o;
        end
    end

    task automatic wait_xfer(input int n);
        int c = 0;
        while (tcnt < n && c < 3000) begin @(negedge clk); c++; end
        if (c >= 3000) chk("timeout_wait_xfer", tcnt, n);
    endtask

    task automatic run_fetch(input logic [7:0] mx, input logic [7:0] my, input logic [7:0] pw,
                             input logic [31:0] yb, input logic [31:0] uvb,
                             input bit mid_start, input int rst_at);
        logic [31:0] a, stride;
        int c;
        stride = {20'd0, pw, 4'b0000};
        for (int k = 0; k < 48; k++) begin
            if (k < 32) a = yb + (32'(my) * 32'd16 + 32'(k >> 1)) * stride + 32'(mx) * 32'd16 + 32'(8 * (k & 1));
            else a = uvb + (32'(my) * 32'd8 + 32'((k - 32) >> 1)) * stride + 32'(mx) * 32'd16 + 32'(8 * (k & 1));
            exp_addr_q.push_back(a);
            exp_data_q.push_back((a == SPECIAL) ? 64'h0001020304050607 : brev(data_fn(a)));
        end
        @(negedge clk);
        gcnt = 0; tcnt = 0; ls_cnt = 0; fd_cnt = 0; viol = 0; max_out = 0; req_drop = 0;
        done_seen = 1'b0; done_it = 0; last_xfer_it = 0;
        mb_x_i = mx; mb_y_i = my; pic_width_mb_i = pw; y_base_i = yb; uv_base_i = uvb; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        if (mid_start) begin
            wait_xfer(5);
            mb_x_i = 8'd7; mb_y_i = 8'd3; start_i = 1'b1;
            @(negedge clk); start_i = 1'b0;
        end
        if (rst_at > 0) begin
            wait_xfer(rst_at);
            @(negedge clk); mon_en = 1'b0; rst_n = 1'b0; #1;
            chk("rst_busy", busy_o, 1'b0);
            chk("rst_pvalid", pvalid_o, 1'b0);
            chk("rst_mem_req", mem_req_o, 1'b0);
            repeat (3) @(negedge clk);
            exp_addr_q.delete(); exp_data_q.delete();
            rst_n = 1'b1; mon_en = 1'b1;
            return;
        end
        c = 0;
        while (!done_seen && c < 5000) begin @(negedge clk); c++; end
        if (c >= 5000) chk("timeout_fetch_done", done_seen, 1'b1);
        @(negedge clk); #2;
        chk("xfer_count", tcnt, 48);
        chk("load_start_pulses", ls_cnt, 1);
        chk("fetch_done_pulses", fd_cnt, 1);
        chk("done_after_last_xfer", done_it, last_xfer_it + 1);
        chk("busy_after_done", busy_o, 1'b0);
        chk("addr_q_empty", exp_addr_q.size(), 0);
        chk("data_q_empty", exp_data_q.size(), 0);
        chk("credit_violations", viol, 0);
        chk("max_outstanding_le_depth", (max_out <= DEPTH), 1'b1);
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", fetch_done_o, 1'b0);
        chk("reset_load_start", load_start_o, 1'b0);
        chk("reset_mem_req", mem_req_o, 1'b0);
        chk("reset_mem_addr", mem_addr_o, 32'd0);
        chk("reset_pvalid", pvalid_o, 1'b0);
        chk("reset_pdata", pdata_o, 64'd0);
        @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;

        // Zero-wait memory, always ready; first word exercises byte order.
        gnt_mode = 0; lat_max = 1; rdy_mode = 0;
        run_fetch(8'd0, 8'd0, 8'd4, SPECIAL, 32'h0002_0000, 1'b0, 0);
        chk("addr1", addr_log[1], SPECIAL + 32'd8);
        chk("addr2", addr_log[2], SPECIAL + 32'd64);
        chk("addr3", addr_log[3], SPECIAL + 32'd72);
        chk("addr31_last_luma", addr_log[31], SPECIAL + 32'd968);
        chk("addr32_first_uv", addr_log[32], 32'h0002_0000);
        chk("addr47_last_uv", addr_log[47], 32'h0002_0000 + 32'd456);

        // Long downstream stall mid-luma: requests must throttle at FIFO depth.
        rdy_mode = 1; stall_at = 10; stall_left = 20;
        run_fetch(8'd1, 8'd2, 8'd5, 32'h2000_0000, 32'h2100_0000, 1'b0, 0);
        chk("max_outstanding_eq_depth", max_out, DEPTH);
        chk("req_dropped_in_stall", (req_drop > 0), 1'b1);

        // Random grant, random return latency, random ready.
        gnt_mode = 1; lat_max = 10; rdy_mode = 2;
        run_fetch(8'd3, 8'd1, 8'd6, 32'h3000_0008, 32'h3800_0010, 1'b0, 0);

        // Address wrap modulo 2^32.
        run_fetch(8'd1, 8'd1, 8'd2, 32'hFFFF_FF00, 32'hFFFF_FFC0, 1'b0, 0);

        // start_i during ISSUE is ignored.
        gnt_mode = 0; lat_max = 1; rdy_mode = 0;
        run_fetch(8'd2, 8'd2, 8'd4, 32'h4000_0000, 32'h4100_0000, 1'b1, 0);

        // Reset at word 20, then a clean refetch.
        run_fetch(8'd1, 8'd0, 8'd4, 32'h5000_0000, 32'h5100_0000, 1'b0, 20);
        run_fetch(8'd1, 8'd0, 8'd4, 32'h5000_0000, 32'h5100_0000, 1'b0, 0);

`ifdef MB_FETCH_STALL_CNT_EN
        rdy_mode = 3; stall_left = 7;
        run_fetch(8'd0, 8'd1, 8'd3, 32'h6000_0000, 32'h6100_0000, 1'b0, 0);
        chk("stall_cnt", stall_cnt_o, 16'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
